// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants for the multi-byte add/subtract sequencer.
// Holds the controller state encoding and the datapath byte width.
// No logic here; imported by the interface, adder and sequencer.
package multibyte_add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multibyte_add_seq_if.sv
// Requester-side bundle for the multi-byte add/subtract sequencer.
// master = requester (drives start/operands), slave = sequencer.
// start is only honoured while busy is low; done is a one-cycle pulse.
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
);
  import multibyte_add_seq_pkg::*;

  localparam int W = BYTE_W * NBYTES;

  logic         start;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, op_sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, op_sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/multibyte_add_seq_adder.sv
// 8-bit hybrid adder: two 4-bit carry-lookahead groups, carry rippled between them.
// Latency: purely combinational.
// Backpressure: none; it is a datapath block.
module hybridadder8_struct
  import multibyte_add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] Xi,
  input  logic [BYTE_W-1:0] Yi,
  input  logic              C0,
  output logic [BYTE_W-1:0] Si,
  output logic              C8
);

  // Lookahead carries c1..c4 of one nibble, returned as {c4,c3,c2,c1}.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [3:0]        c_lo;
  logic [3:0]        c_hi;

  assign gen  = Xi & Yi;
  assign prop = Xi ^ Yi;
  assign c_lo = cla4(gen[3:0], prop[3:0], C0);
  assign c_hi = cla4(gen[7:4], prop[7:4], c_lo[3]);
  assign Si   = prop ^ {c_hi[2:0], c_lo[3], c_lo[2:0], C0};
  assign C8   = c_hi[3];

endmodule

// File: rtl/multibyte_add_seq.sv
// Wide add/subtract sequenced one byte per cycle (LSB first) through a shared 8-bit adder.
// Latency: done pulses NBYTES+1 cycles after the accepting start edge.
// Backpressure: start is ignored while busy (RUN/DONE); requester must hold or retry it.
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  multibyte_add_seq_if.slave  bus
);

  localparam int              W    = BYTE_W * NBYTES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic              op_sub_q, cin_q, carry_q, cout_q, ovf_q;
  logic              busy, done;

  logic [BYTE_W-1:0] add_x, add_y, add_s;
  logic              add_c0, add_c8;
  logic              last_byte;

  assign last_byte = (cnt_q == LAST);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_byte) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Adder drive: the low byte of the shifted operands; quiet (all zero) outside RUN.
  always_comb begin
    add_x  = '0;
    add_y  = '0;
    add_c0 = 1'b0;
    if (state_q == ST_RUN) begin
      add_x  = a_q[BYTE_W-1:0];
      add_y  = op_sub_q ? ~b_q[BYTE_W-1:0] : b_q[BYTE_W-1:0];
      add_c0 = (cnt_q == '0) ? (op_sub_q | cin_q) : carry_q;
    end
  end

  hybridadder8_struct u_adder (
    .Xi (add_x),
    .Yi (add_y),
    .C0 (add_c0),
    .Si (add_s),
    .C8 (add_c8)
  );

  // Operand capture/shift, byte counter, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      op_sub_q <= 1'b0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q   <= '0;
          carry_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_sub_q <= bus.op_sub;
            cin_q    <= bus.cin;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (cnt_q == CNT_W'(k)) sum_q[k*BYTE_W +: BYTE_W] <= add_s;
          end
          carry_q <= add_c8;
          a_q     <= a_q >> BYTE_W;
          b_q     <= b_q >> BYTE_W;
          if (last_byte) begin
            // The low bytes now hold the operand MSB bytes, so bit 7 is the sign.
            cout_q <= add_c8;
            ovf_q  <= (add_x[BYTE_W-1] == add_y[BYTE_W-1]) && (add_s[BYTE_W-1] != add_x[BYTE_W-1]);
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq (NBYTES=4): directed vectors with hand-computed results,
// plus a per-cycle comparison against an arithmetic model of the requester contract.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_multibyte_add_seq;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  multibyte_add_seq_if #(.NBYTES(NB)) bus ();

  multibyte_add_seq #(.NBYTES(NB), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Result of a W-bit add/subtract from plain arithmetic: {ovf, cout, sum}.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic ms, input logic mc);
    logic [31:0] yeff;
    logic [32:0] full;
    logic        v;
    yeff = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, yeff} + {32'd0, (ms ? 1'b1 : mc)};
    v    = (ma[31] == yeff[31]) && (full[31] != ma[31]);
    return {v, full[32], full[31:0]};
  endfunction

  // Reference model of the requester-visible behaviour.
  logic        m_pend = 1'b0;
  int          m_start = 0;
  int          m_idle_from = 0;
  logic [33:0] m_exp = '0;
  logic [33:0] m_last = '0;
  logic        e_busy, e_done;

  always @(negedge clk) begin
    e_busy = m_pend && (cyc > m_start) && (cyc <= m_start + NB + 1);
    e_done = m_pend && (cyc == m_start + NB + 1);
    chk("m_busy", bus.busy, e_busy);
    chk("m_done", bus.done, e_done);
    if (e_done) begin
      chk("m_sum",  bus.sum,  m_exp[31:0]);
      chk("m_cout", bus.cout, m_exp[32]);
      chk("m_ovf",  bus.ovf,  m_exp[33]);
      m_last = m_exp;
      m_pend = 1'b0;
    end else if (!e_busy) begin
      chk("m_hold_sum",  bus.sum,  m_last[31:0]);
      chk("m_hold_cout", bus.cout, m_last[32]);
      chk("m_hold_ovf",  bus.ovf,  m_last[33]);
    end
    if (rst) begin
      m_pend      = 1'b0;
      m_last      = '0;
      m_idle_from = cyc + 1;
    end else if (bus.start && !m_pend && cyc >= m_idle_from) begin
      m_pend      = 1'b1;
      m_start     = cyc;
      m_exp       = model(bus.a, bus.b, bus.op_sub, bus.cin);
      m_idle_from = cyc + NB + 2;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic tc,
                        input logic [31:0] ls, input logic lc, input logic lo);
    int t0;
    int k;
    bit seen;
    next_cyc();
    bus.a = ta; bus.b = tb_v; bus.op_sub = ts; bus.cin = tc; bus.start = 1'b1;
    t0 = cyc;
    next_cyc();
    bus.start = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else k++;
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({nm, "_latency"}, cyc - t0, 5);
      chk({nm, "_sum"},  bus.sum,  ls);
      chk({nm, "_cout"}, bus.cout, lc);
      chk({nm, "_ovf"},  bus.ovf,  lo);
    end
  endtask

  initial begin
    int t0;
    int ndone;
    logic [31:0] dsum;
    int dcyc[$];

    bus.start = 1'b0; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_sum",  bus.sum,  32'h0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_ovf",  bus.ovf,  1'b0);

    run_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("add_cin",    32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0);
    run_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Second start two cycles in must not disturb the operation in flight.
    next_cyc();
    bus.a = 32'd1; bus.b = 32'd1; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    next_cyc();
    bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    ndone = 0;
    dsum = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        dsum = bus.sum;
      end
    end
    chk("hs_done_count", ndone, 1);
    chk("hs_sum", dsum, 32'h00000002);

    // start held high: a new operation on every return to IDLE.
    next_cyc();
    bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcyc.push_back(cyc);
    end
    next_cyc();
    bus.start = 1'b0;
    chk("held_done_count", dcyc.size(), 3);
    if (dcyc.size() >= 3) begin
      chk("held_first", dcyc[0] - t0, 5);
      chk("held_gap0", dcyc[1] - dcyc[0], 6);
      chk("held_gap1", dcyc[2] - dcyc[1], 6);
      chk("held_sum", bus.sum, 32'h00000007);
    end
    repeat (6) @(posedge clk);

    // Reset two cycles into an operation aborts it with no done pulse.
    next_cyc();
    bus.a = 32'h00000100; bus.b = 32'h00000200; bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_sum",  bus.sum,  32'h0);
    chk("abort_cout", bus.cout, 1'b0);
    chk("abort_ovf",  bus.ovf,  1'b0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    run_op("after_abort", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
